// File: rtl/cntry_car_sensor.sv
`default_nettype none
// ============================================================================
// Module      : cntry_car_sensor
// Description : Country-road vehicle-loop conditioner. Synchronises and
//               debounces the raw loop detector, counts waiting cars, drains
//               the count while the country light is GREEN, and raises the
//               X request while cars wait. A loop that stays high for too
//               long is flagged as faulty and forces X high (fail-safe).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1      system clock, all logic on posedge
//   clear        in   1      synchronous active-high reset
//   sensor_raw   in   1      asynchronous loop detector, 1 = metal present
//   cntry        in   2      country light: RED=0, YELLOW=1, GREEN=2 (3 = not GREEN)
//   X            out  1      1 = car(s) waiting on the country road
//   car_count    out  CNT_W  current waiting-car estimate
//   sensor_fault out  1      1 = loop stuck high
// ============================================================================
module cntry_car_sensor #(
  parameter int DEBOUNCE     = 4,
  parameter int CNT_W        = 4,
  parameter int MAX_CARS     = 15,
  parameter int DRAIN_CYCLES = 8,
  parameter int STUCK_CYCLES = 255
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sensor_raw,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             sensor_fault
);

  // Counter widths; each must hold its terminal value.
  localparam int c_DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int c_DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int c_ST_W = $clog2(STUCK_CYCLES + 1);

  localparam logic [1:0]        c_GREEN     = 2'd2;
  localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE - 1);
  localparam logic [c_DR_W-1:0] c_DR_LAST   = c_DR_W'(DRAIN_CYCLES - 1);
  localparam logic [c_ST_W-1:0] c_STUCK_MAX = c_ST_W'(STUCK_CYCLES);
  localparam logic [c_ST_W-1:0] c_STUCK_PRE = c_ST_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_CARS_MAX  = CNT_W'(MAX_CARS);

  // Synchroniser and debounce state
  logic              r_s1;
  logic              r_s2;
  logic              r_filt;
  logic [c_DB_W-1:0] r_db_cnt;

  // Counting state
  logic [CNT_W-1:0]  r_car_count;
  logic [c_DR_W-1:0] r_drain_cnt;
  logic [c_ST_W-1:0] r_stuck_cnt;
  logic              r_fault;

  // Combinational events
  logic w_db_done;
  logic w_arrival;
  logic w_drain_en;
  logic w_tick;

  // The filtered level flips on this edge when the synchronised level has
  // disagreed with it for DEBOUNCE consecutive cycles.
  assign w_db_done = (r_s2 != r_filt) && (r_db_cnt == c_DB_LAST);

  // An arrival is the 0->1 flip of the filtered level. It is taken from the
  // debounce decision rather than from a delayed copy of r_filt, so the car
  // is counted on the same edge the filtered level rises.
  assign w_arrival = w_db_done && r_s2 && !r_fault;

  // Drain timer only runs while there is someone to let through.
  assign w_drain_en = (cntry == c_GREEN) && (r_car_count != '0);
  assign w_tick     = w_drain_en && (r_drain_cnt == c_DR_LAST);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sensor_raw;
      r_s2 <= r_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce filter: any disagreement shorter than DEBOUNCE cycles resets
  // the run counter and leaves the filtered level untouched.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      r_filt   <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_s2 != r_filt) begin
      if (w_db_done) begin
        r_filt   <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Drain timer: one tick per DRAIN_CYCLES GREEN cycles with cars waiting.
  // Any break in GREEN restarts the interval from zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      r_drain_cnt <= '0;
    end else if (!w_drain_en || w_tick) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Car counter. An arrival and a departure on the same edge cancel out.
  // A tick can only occur with car_count > 0, so the decrement never wraps.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      r_car_count <= '0;
    end else begin
      case ({w_arrival, w_tick})
        2'b10: begin
          if (r_car_count != c_CARS_MAX) begin
            r_car_count <= r_car_count + 1'b1;
          end
        end
        2'b01:   r_car_count <= r_car_count - 1'b1;
        default: r_car_count <= r_car_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stuck-loop detector. The fault is set on the edge the counter reaches
  // STUCK_CYCLES and released as soon as the filtered level is seen low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      r_stuck_cnt <= '0;
      r_fault     <= 1'b0;
    end else if (!r_filt) begin
      r_stuck_cnt <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (r_stuck_cnt != c_STUCK_MAX) begin
        r_stuck_cnt <= r_stuck_cnt + 1'b1;
      end
      if (r_stuck_cnt >= c_STUCK_PRE) begin
        r_fault <= 1'b1;
      end
    end
  end

  // Outputs decoded purely from registers: glitch-free, no added latency.
  assign car_count    = r_car_count;
  assign sensor_fault = r_fault;
  assign X            = (r_car_count != '0) | r_fault;

endmodule
`default_nettype wire
